// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I sequencer (addi/bne) with a
// variable-latency fetch handshake, IR register and datapath controls.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   run                   execute enable, sampled in IDLE and WB
//   imem_req/ack/rdata    instruction fetch handshake (ack only in FETCH)
//   EQ                    ALU equal flag, used for bne in WB
//   ir                    instruction register
//   RegWrite, ALUctrl,    datapath controls
//   ALUsrc, ImmSrc, PCsrc
//   pc_we                 PC write enable, one pulse per retired instr
//   busy                  high outside IDLE and TRAP
//   illegal               high while in TRAP (sticky until reset)
//   instret               retired-instruction counter, present only
//                         when MULTICYCLE_CTRL_INSTRET_EN is defined
module multicycle_ctrl #(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic [D_WIDTH-1:0] imem_rdata,
    input  logic               EQ,
    output logic [D_WIDTH-1:0] ir,
    output logic               RegWrite,
    output logic               ALUctrl,
    output logic               ALUsrc,
    output logic               ImmSrc,
    output logic               PCsrc,
    output logic               pc_we,
    output logic               busy,
    output logic               illegal
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    ,
    output logic [31:0]        instret
`endif
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] TRAP   = 3'd5;

    logic [2:0] state;
    logic [2:0] state_nx;
    logic       is_addi;
    logic       is_bne;
    logic       in_ex;
    logic       in_wb;

    assign is_addi = (ir[6:0] == 7'd19) && (ir[14:12] == 3'b000);
    assign is_bne  = (ir[6:0] == 7'd99) && (ir[14:12] == 3'b001);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (run) state_nx = FETCH;
            FETCH:   if (imem_ack) state_nx = DECODE;
            DECODE:  state_nx = (is_addi || is_bne) ? EXEC : TRAP;
            EXEC:    state_nx = WB;
            WB:      state_nx = run ? FETCH : IDLE;
            TRAP:    state_nx = TRAP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ir    <= '0;
        end else begin
            state <= state_nx;
            if (state == FETCH && imem_ack)
                ir <= imem_rdata;
        end
    end

    // WB keeps the EXEC operand selection so the ALU result stays
    // stable while it is written back.
    assign in_wb = (state == WB);
    assign in_ex = (state == EXEC) || in_wb;

    assign imem_req = (state == FETCH);
    assign ALUctrl  = in_ex & is_addi;
    assign ALUsrc   = in_ex & is_addi;
    assign ImmSrc   = in_ex & (is_addi | is_bne);
    assign RegWrite = in_wb & is_addi;
    assign PCsrc    = in_wb & is_bne & ~EQ;
    assign pc_we    = in_wb;
    assign busy     = (state != IDLE) && (state != TRAP);
    assign illegal  = (state == TRAP);

`ifdef MULTICYCLE_CTRL_INSTRET_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instret_q <= '0;
        else if (in_wb)
            instret_q <= instret_q + 32'd1;
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven and scoreboard checks for
// multicycle_ctrl (fetch handshake, decode, exec, writeback, trap).
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        EQ = 1'b0;
    logic [31:0] ir;
    logic        RegWrite, ALUctrl, ALUsrc, ImmSrc, PCsrc;
    logic        pc_we, busy, illegal;
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    logic [31:0] instret;
`endif

    multicycle_ctrl #(.D_WIDTH(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .run(run),
        .imem_req(imem_req),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .EQ(EQ),
        .ir(ir),
        .RegWrite(RegWrite),
        .ALUctrl(ALUctrl),
        .ALUsrc(ALUsrc),
        .ImmSrc(ImmSrc),
        .PCsrc(PCsrc),
        .pc_we(pc_we),
        .busy(busy),
        .illegal(illegal)
`ifdef MULTICYCLE_CTRL_INSTRET_EN
        ,
        .instret(instret)
`endif
    );

    always #5 clk = ~clk;

    // {imem_req,RegWrite,ALUctrl,ALUsrc,ImmSrc,PCsrc,pc_we,busy,illegal}
    logic [8:0] ctl;
    assign ctl = {imem_req, RegWrite, ALUctrl, ALUsrc, ImmSrc,
                  PCsrc, pc_we, busy, illegal};

    localparam logic [8:0] C_IDLE   = 9'b000000000;
    localparam logic [8:0] C_FETCH  = 9'b100000010;
    localparam logic [8:0] C_DECODE = 9'b000000010;
    localparam logic [8:0] C_TRAP   = 9'b000000001;

    typedef struct {
        logic [31:0] rdata;
        int          delay;
        logic        eq;
        logic        trap;
        logic        rw;
        logic        pcs;
        logic        alu;
        logic        src;
    } vec_t;

    typedef struct {
        logic [31:0] ir;
        logic        rw;
        logic        pcs;
        logic        alu;
        logic        src;
    } exp_t;

    vec_t        vecs[8];
    exp_t        sb[$];
    exp_t        me;
    logic [31:0] cur_ir = '0;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Writeback monitor: every pc_we pulse must match the oldest
    // expectation pushed when its instruction was driven.
    always @(posedge clk) begin
        #1;
        if (rst_n && pc_we) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected_pc_we", 32'd1, 32'd0);
            end else begin
                me = sb.pop_front();
                chk("wb_ir", ir, me.ir);
                chk("wb_RegWrite", {31'd0, RegWrite}, {31'd0, me.rw});
                chk("wb_PCsrc", {31'd0, PCsrc}, {31'd0, me.pcs});
                chk("wb_ALUctrl", {31'd0, ALUctrl}, {31'd0, me.alu});
                chk("wb_ALUsrc", {31'd0, ALUsrc}, {31'd0, me.src});
                chk("wb_ImmSrc", {31'd0, ImmSrc}, 32'd1);
                chk("wb_busy", {31'd0, busy}, 32'd1);
                chk("wb_req", {31'd0, imem_req}, 32'd0);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ctl", {23'd0, ctl}, {23'd0, C_IDLE});
        chk("rst_ir", ir, 32'd0);
        cur_ir = '0;
        run = 1'b0;
        imem_ack = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic push_exp(input logic [31:0] r, input logic rw,
                            input logic pcs, input logic alu,
                            input logic src);
        exp_t e;
        e.ir = r;
        e.rw = rw;
        e.pcs = pcs;
        e.alu = alu;
        e.src = src;
        sb.push_back(e);
    endtask

    // Starts from IDLE with all inputs low; ends back in IDLE.
    task automatic run_vec(input vec_t v);
        int busy_cyc;
        busy_cyc = 0;
        EQ = v.eq;
        imem_rdata = v.rdata;
        if (!v.trap) push_exp(v.rdata, v.rw, v.pcs, v.alu, v.src);
        run = 1'b1;
        for (int w = 0; w <= v.delay; w++) begin
            @(posedge clk); #1;
            busy_cyc++;
            chk("fetch_ctl", {23'd0, ctl}, {23'd0, C_FETCH});
            chk("fetch_ir_hold", ir, cur_ir);
            run = 1'b0;
            imem_ack = (w == v.delay);
        end
        @(posedge clk); #1;
        busy_cyc++;
        cur_ir = v.rdata;
        chk("dec_ctl", {23'd0, ctl}, {23'd0, C_DECODE});
        chk("dec_ir", ir, cur_ir);
        imem_rdata = ~v.rdata;
        imem_ack = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        imem_rdata = v.rdata;
        chk("post_dec_ir", ir, cur_ir);
        if (v.trap) begin
            chk("trap_ctl", {23'd0, ctl}, {23'd0, C_TRAP});
            for (int i = 0; i < 4; i++) begin
                run = ~run;
                @(posedge clk); #1;
                chk("trap_sticky", {23'd0, ctl}, {23'd0, C_TRAP});
            end
            run = 1'b0;
            do_reset();
            @(posedge clk); #1;
            chk("trap_exit_idle", {23'd0, ctl}, {23'd0, C_IDLE});
        end else begin
            busy_cyc++;
            chk("exec_ctl", {23'd0, ctl},
                {23'd0, 2'b00, v.alu, v.src, 5'b10010});
            @(posedge clk); #1;
            busy_cyc += busy;
            @(posedge clk); #1;
            chk("end_idle", {23'd0, ctl}, {23'd0, C_IDLE});
            chk("latency", busy_cyc, 4 + v.delay);
            chk("sb_drained", sb.size(), 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{32'h00500093, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{32'h00009463, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h00009463, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'hFFF00093, 3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{32'h00009463, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{32'h00000033, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h00501093, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{32'h00008463, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        #12;
        do_reset();
        @(posedge clk); #1;
        chk("idle_after_reset", {23'd0, ctl}, {23'd0, C_IDLE});

`ifdef MULTICYCLE_CTRL_INSTRET_EN
        chk("instret_reset", instret, 32'd0);
        for (int i = 0; i < 3; i++) run_vec(vecs[0]);
        chk("instret_3", instret, 32'd3);
        dut.instret_q = 32'hFFFF_FFFF;
        run_vec(vecs[0]);
        chk("instret_wrap", instret, 32'd0);
`endif

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Back-to-back addi, run dropped in the second EXEC.
        EQ = 1'b0;
        imem_rdata = 32'h00500093;
        push_exp(32'h00500093, 1'b1, 1'b0, 1'b1, 1'b1);
        run = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("b2b_wb_pc_we", {31'd0, pc_we}, 32'd1);
        @(posedge clk); #1;
        chk("b2b_refetch", {23'd0, ctl}, {23'd0, C_FETCH});
        imem_rdata = 32'h00A00113;
        push_exp(32'h00A00113, 1'b1, 1'b0, 1'b1, 1'b1);
        imem_ack = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        @(posedge clk); #1;
        run = 1'b0;
        @(posedge clk); #1;
        chk("drop_wb_RegWrite", {31'd0, RegWrite}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("drop_idle", {23'd0, ctl}, {23'd0, C_IDLE});
        end
        chk("drop_sb", sb.size(), 32'd0);

        // Reset asserted in EXEC discards the instruction.
        imem_rdata = 32'h00500093;
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        imem_ack = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        @(posedge clk); #1;
        chk("rexec_ctl", {23'd0, ctl}, {23'd0, 9'b001110010});
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rexec_idle", {23'd0, ctl}, {23'd0, C_IDLE});
        end
        chk("rexec_ir", ir, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
